lcd_hd44780_sched: RTL and testbench

//  Byte-level scheduler for the HD44780 character LCD on the 4-bit bus (RS, E, D7..D4).

---
 rtl/lcd_hd44780_sched.sv | 191 +++++++++++++++++++
 tb/tb_lcd_hd44780_sched.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_sched.sv
// HD44780 4-bit bus scheduler: runs power-up init, then sends requested command/data
// bytes as two nibbles with E pulse timing and execution waits.
module lcd_hd44780_sched #(
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_EPW       = 8,
  parameter int unsigned T_NIB       = 16,
  parameter int unsigned T_EXEC      = 64,
  parameter int unsigned T_EXEC_LONG = 2048,
  parameter int unsigned T_POWERUP   = 16384
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [3:0] lcd_d
);

  localparam int unsigned M0   = (T_SETUP > T_EPW) ? T_SETUP : T_EPW;
  localparam int unsigned M1   = (M0 > T_NIB) ? M0 : T_NIB;
  localparam int unsigned M2   = (M1 > T_EXEC) ? M1 : T_EXEC;
  localparam int unsigned M3   = (M2 > T_EXEC_LONG) ? M2 : T_EXEC_LONG;
  localparam int unsigned MaxT = (M3 > T_POWERUP) ? M3 : T_POWERUP;
  localparam int unsigned CntW = $clog2(MaxT + 1);

  typedef enum logic [2:0] {StPwrup, StSetup, StPulse, StGap, StExec, StIdle} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, lim;
  logic [2:0]      step_q, step_d, nxt_step;
  logic [7:0]      byte_q, byte_d;
  logic            rs_q, rs_d, e_q, e_d, ready_q, ready_d, done_q, done_d;
  logic [3:0]      d_q, d_d;
  logic            long_q, long_d, nib_only_q, nib_only_d, low_q, low_d;
  logic            expired;
  logic [9:0]      rom;

  // {nibble_only, long_wait, byte}; the first four steps send only the high nibble.
  function automatic logic [9:0] init_rom(input logic [2:0] step);
    unique case (step)
      3'd0, 3'd1, 3'd2: init_rom = {1'b1, 1'b1, 8'h30};
      3'd3:             init_rom = {1'b1, 1'b0, 8'h20};
      3'd4:             init_rom = {1'b0, 1'b0, 8'h28};
      3'd5:             init_rom = {1'b0, 1'b0, 8'h0C};
      3'd6:             init_rom = {1'b0, 1'b0, 8'h06};
      default:          init_rom = {1'b0, 1'b1, 8'h01};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StPwrup;
      cnt_q      <= '0;
      step_q     <= '0;
      byte_q     <= '0;
      rs_q       <= 1'b0;
      e_q        <= 1'b0;
      d_q        <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      long_q     <= 1'b0;
      nib_only_q <= 1'b0;
      low_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      byte_q     <= byte_d;
      rs_q       <= rs_d;
      e_q        <= e_d;
      d_q        <= d_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      long_q     <= long_d;
      nib_only_q <= nib_only_d;
      low_q      <= low_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    byte_d     = byte_q;
    rs_d       = rs_q;
    e_d        = e_q;
    d_d        = d_q;
    ready_d    = ready_q;
    done_d     = done_q;
    long_d     = long_q;
    nib_only_d = nib_only_q;
    low_d      = low_q;

    unique case (state_q)
      StPwrup: lim = CntW'(T_POWERUP - 1);
      StSetup: lim = CntW'(T_SETUP - 1);
      StPulse: lim = CntW'(T_EPW - 1);
      StGap:   lim = CntW'(T_NIB - 1);
      StExec:  lim = long_q ? CntW'(T_EXEC_LONG - 1) : CntW'(T_EXEC - 1);
      default: lim = '0;
    endcase
    expired  = (cnt_q == lim);
    cnt_d    = expired ? '0 : cnt_q + CntW'(1);
    nxt_step = (state_q == StPwrup) ? 3'd0 : step_q + 3'd1;
    rom      = init_rom(nxt_step);

    unique case (state_q)
      StPwrup: begin
        if (expired) begin
          state_d    = StSetup;
          step_d     = nxt_step;
          byte_d     = rom[7:0];
          rs_d       = 1'b0;
          d_d        = rom[7:4];
          nib_only_d = rom[9];
          long_d     = rom[8];
          low_d      = 1'b0;
        end
      end
      StSetup: begin
        if (expired) begin
          state_d = StPulse;
          e_d     = 1'b1;
        end
      end
      StPulse: begin
        if (expired) begin
          e_d     = 1'b0;
          state_d = (nib_only_q || low_q) ? StExec : StGap;
        end
      end
      StGap: begin
        if (expired) begin
          state_d = StSetup;
          d_d     = byte_q[3:0];
          low_d   = 1'b1;
        end
      end
      StExec: begin
        if (expired) begin
          if (done_q || step_q == 3'd7) begin
            state_d = StIdle;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d    = StSetup;
            step_d     = nxt_step;
            byte_d     = rom[7:0];
            rs_d       = 1'b0;
            d_d        = rom[7:4];
            nib_only_d = rom[9];
            long_d     = rom[8];
            low_d      = 1'b0;
          end
        end
      end
      StIdle: begin
        cnt_d = '0;
        if (req_valid) begin
          state_d    = StSetup;
          byte_d     = req_data;
          rs_d       = req_rs;
          d_d        = req_data[7:4];
          nib_only_d = 1'b0;
          low_d      = 1'b0;
          ready_d    = 1'b0;
          // Clear and return-home need the long execution wait.
          long_d     = !req_rs && (req_data[7:2] == 6'd0) && (req_data != 8'd0);
        end
      end
      default: begin
        state_d = StPwrup;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    req_ready = ready_q;
    busy      = ~ready_q;
    init_done = done_q;
    lcd_rs    = rs_q;
    lcd_e     = e_q;
    lcd_d     = d_q;
  end

endmodule

// File: tb/tb_lcd_hd44780_sched.sv
// Directed bench for lcd_hd44780_sched at default timing: init, byte transfers, busy
// behaviour and mid-transfer reset.
module tb_lcd_hd44780_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, init_done, busy, lcd_rs, lcd_e;
  logic [3:0] lcd_d;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rise_cyc[$];
  logic [3:0] rise_d[$];
  logic rise_rs[$];
  int last_fall = -1;
  logic e_prev = 1'b0;

  lcd_hd44780_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .req_ready (req_ready),
    .init_done (init_done),
    .busy      (busy),
    .lcd_rs    (lcd_rs),
    .lcd_e     (lcd_e),
    .lcd_d     (lcd_d)
  );

  always #5 clk = ~clk;

  // cyc = number of posedges since reset release, as seen at the following negedge
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (lcd_e && !e_prev) begin
      rise_cyc.push_back(cyc);
      rise_d.push_back(lcd_d);
      rise_rs.push_back(lcd_rs);
    end
    if (!lcd_e && e_prev) last_fall = cyc;
    e_prev <= lcd_e;
  end

  task automatic clear_log();
    rise_cyc.delete();
    rise_d.delete();
    rise_rs.delete();
  endtask

  task automatic wait_ready(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (req_ready) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic send(input logic rs, input logic [7:0] data, output int k);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_ready: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = data;
    k = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic bad;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({lcd_rs, lcd_e, lcd_d, req_ready, init_done} !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_hold: rs=%b e=%b d=%h ready=%b done=%b required all 0",
               lcd_rs, lcd_e, lcd_d, req_ready, init_done);
    end
    // requests during power-up must be ignored
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'hFF;
    rst_n     = 1'b1;
    bad       = 1'b0;
    while (cyc < 16383) begin
      @(negedge clk);
      if ({lcd_rs, lcd_e, lcd_d, req_ready, init_done} !== 8'd0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL powerup_quiet: outputs nonzero before cycle 16384, required all 0");
    end
    @(negedge clk);
    vectors++;
    if (lcd_d !== 4'h3 || lcd_e !== 1'b0 || lcd_rs !== 1'b0) begin
      miscompares++;
      $display("FAIL first_nibble_bus: d=%h e=%b rs=%b at %0d required d=3 e=0 rs=0",
               lcd_d, lcd_e, lcd_rs, cyc);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_init();
    logic [3:0] exp_d [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC,
                               4'h0, 4'h6, 4'h0, 4'h1};
    int at = -1;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (init_done) begin
        at = cyc;
        break;
      end
    end
    vectors++;
    if (at != 25016) begin
      miscompares++;
      $display("FAIL init_done_cycle: got %0d required 25016", at);
    end
    vectors++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL init_ready: ready=%b busy=%b required 1/0", req_ready, busy);
    end
    vectors++;
    if (rise_cyc.size() != 12) begin
      miscompares++;
      $display("FAIL init_pulse_count: got %0d required 12", rise_cyc.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        vectors++;
        if (rise_d[i] !== exp_d[i] || rise_rs[i] !== 1'b0) begin
          miscompares++;
          $display("FAIL init_nibble_%0d: d=%h rs=%b required d=%h rs=0",
                   i, rise_d[i], rise_rs[i], exp_d[i]);
        end
      end
      vectors++;
      if (rise_cyc[0] != 16386) begin
        miscompares++;
        $display("FAIL init_first_rise: got %0d required 16386", rise_cyc[0]);
      end
    end
    vectors++;
    if (last_fall != 22968 || at - last_fall != 2048) begin
      miscompares++;
      $display("FAIL init_last_fall: fall=%0d done=%0d required 22968 and gap 2048",
               last_fall, at);
    end
  endtask

  // Two-nibble transfer: pulses at k+2 and k+28, ready again at k+ready_ofs.
  task automatic test_byte(input string name, input logic rs, input logic [7:0] data,
                           input int ready_ofs);
    int k, at;
    clear_log();
    send(rs, data, k);
    wait_ready(3000, at);
    vectors++;
    if (at != k + ready_ofs) begin
      miscompares++;
      $display("FAIL %s_ready: got %0d required %0d", name, at, k + ready_ofs);
    end
    vectors++;
    if (rise_cyc.size() != 2) begin
      miscompares++;
      $display("FAIL %s_pulses: got %0d pulses required 2", name, rise_cyc.size());
    end else begin
      vectors++;
      if (rise_d[0] !== data[7:4] || rise_d[1] !== data[3:0] ||
          rise_rs[0] !== rs || rise_rs[1] !== rs) begin
        miscompares++;
        $display("FAIL %s_nibbles: %h/%h rs %b/%b required %h/%h rs %b", name,
                 rise_d[0], rise_d[1], rise_rs[0], rise_rs[1], data[7:4], data[3:0], rs);
      end
      vectors++;
      if (rise_cyc[0] != k + 2 || rise_cyc[1] != k + 28) begin
        miscompares++;
        $display("FAIL %s_e_timing: rises %0d,%0d required %0d,%0d", name,
                 rise_cyc[0], rise_cyc[1], k + 2, k + 28);
      end
    end
    vectors++;
    if (lcd_e !== 1'b0 || lcd_d !== data[3:0] || lcd_rs !== rs) begin
      miscompares++;
      $display("FAIL %s_hold: e=%b d=%h rs=%b required e=0 d=%h rs=%b",
               name, lcd_e, lcd_d, lcd_rs, data[3:0], rs);
    end
  endtask

  task automatic test_back_to_back();
    int k, at;
    logic [3:0] exp_d [4] = '{4'h4, 4'h1, 4'h6, 4'h2};
    clear_log();
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h41;
    k = cyc + 1;
    @(negedge clk);
    req_rs   = 1'b0;
    req_data = 8'h7E;
    while (cyc < k + 50) @(negedge clk);
    req_rs   = 1'b1;
    req_data = 8'h62;
    wait_ready(300, at);
    vectors++;
    if (at != k + 100) begin
      miscompares++;
      $display("FAIL b2b_first_ready: got %0d required %0d", at, k + 100);
    end
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: req_ready=%b after ready edge, required 0", req_ready);
    end
    wait_ready(300, at);
    vectors++;
    if (at != k + 201) begin
      miscompares++;
      $display("FAIL b2b_second_ready: got %0d required %0d", at, k + 201);
    end
    vectors++;
    if (rise_cyc.size() != 4) begin
      miscompares++;
      $display("FAIL b2b_pulse_count: got %0d required 4", rise_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (rise_d[i] !== exp_d[i] || rise_rs[i] !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_nibble_%0d: d=%h rs=%b required d=%h rs=1",
                   i, rise_d[i], rise_rs[i], exp_d[i]);
        end
      end
      vectors++;
      if (rise_cyc[2] != k + 103 || rise_cyc[3] != k + 129) begin
        miscompares++;
        $display("FAIL b2b_second_timing: rises %0d,%0d required %0d,%0d",
                 rise_cyc[2], rise_cyc[3], k + 103, k + 129);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_log();
    send(1'b1, 8'h48, k);
    while (cyc < k + 30) @(negedge clk);
    vectors++;
    if (lcd_e !== 1'b1 || lcd_d !== 4'h8) begin
      miscompares++;
      $display("FAIL mid_pulse: e=%b d=%h required e=1 d=8", lcd_e, lcd_d);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (lcd_e !== 1'b0 || init_done !== 1'b0 || req_ready !== 1'b0 || lcd_d !== 4'h0) begin
      miscompares++;
      $display("FAIL mid_async_reset: e=%b done=%b ready=%b d=%h required 0/0/0/0",
               lcd_e, init_done, req_ready, lcd_d);
    end
    repeat (3) @(negedge clk);
    clear_log();
    last_fall = -1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_init();
    test_byte("data_H", 1'b1, 8'h48, 100);
    test_byte("clear", 1'b0, 8'h01, 36 + 2048);
    test_byte("cmd_04", 1'b0, 8'h04, 100);
    test_back_to_back();
    test_reset_mid();
    test_init();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
